// File: rtl/sumac2_segmentado_if.sv
// Operand/result handshake bundle for the segmented add/subtract unit.
// master = producer/consumer side, slave = the arithmetic unit.
interface sumac2_segmentado_if #(
  parameter int ANCHO = 64
);
  logic             in_valid;
  logic             in_ready;
  logic [ANCHO-1:0] a;
  logic [ANCHO-1:0] b;
  logic             resta;
  logic             ci;
  logic             out_valid;
  logic             out_ready;
  logic [ANCHO-1:0] s;
  logic             coutfin;
  logic             desborde;
  logic             cero;
  logic             negativo;

  modport master (
    output in_valid, a, b, resta, ci, out_ready,
    input  in_ready, out_valid, s, coutfin, desborde, cero, negativo
  );

  modport slave (
    input  in_valid, a, b, resta, ci, out_ready,
    output in_ready, out_valid, s, coutfin, desborde, cero, negativo
  );
endinterface

// File: rtl/sumac2_segmentado.sv
// Multi-cycle two's-complement add/subtract: one SEG-bit segment per cycle,
// carry kept in a register between segments; flags produced on the last one.
module sumac2_segmentado #(
  parameter int ANCHO = 64,
  parameter int SEG   = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  sumac2_segmentado_if.slave   bus
);
  localparam int             N   = ANCHO / SEG;
  localparam int             CW  = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0]  ULT = CW'(N - 1);

  typedef enum logic [1:0] {
    LIBRE = 2'd0,
    CALC  = 2'd1,
    LISTO = 2'd2
  } estado_t;

  estado_t          r_estado;
  logic [ANCHO-1:0] r_a;
  logic [ANCHO-1:0] r_b;
  logic             r_carry;
  logic [CW-1:0]    r_cnt;
  logic [ANCHO-1:0] r_s;
  logic             r_coutfin;
  logic             r_desborde;
  logic             r_cero;
  logic             r_negativo;
  logic             r_out_valid;

  logic [SEG-1:0]   w_a_seg;
  logic [SEG-1:0]   w_b_seg;
  logic [SEG-1:0]   w_low;
  logic             w_c_msb;
  logic [1:0]       w_msb;
  logic [SEG-1:0]   w_seg;
  logic [ANCHO-1:0] w_s_next;

  // Segment adder: low SEG-1 bits first so the carry into the MSB is visible for overflow.
  always_comb begin
    w_a_seg  = r_a[r_cnt*SEG +: SEG];
    w_b_seg  = r_b[r_cnt*SEG +: SEG];
    w_low    = {1'b0, w_a_seg[SEG-2:0]} + {1'b0, w_b_seg[SEG-2:0]}
             + {{(SEG-1){1'b0}}, r_carry};
    w_c_msb  = w_low[SEG-1];
    w_msb    = {1'b0, w_a_seg[SEG-1]} + {1'b0, w_b_seg[SEG-1]} + {1'b0, w_c_msb};
    w_seg    = {w_msb[0], w_low[SEG-2:0]};
    w_s_next = r_s;
    w_s_next[r_cnt*SEG +: SEG] = w_seg;
  end

  // Control FSM with datapath and registered result/flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_estado    <= LIBRE;
      r_a         <= {ANCHO{1'b0}};
      r_b         <= {ANCHO{1'b0}};
      r_carry     <= 1'b0;
      r_cnt       <= {CW{1'b0}};
      r_s         <= {ANCHO{1'b0}};
      r_coutfin   <= 1'b0;
      r_desborde  <= 1'b0;
      r_cero      <= 1'b0;
      r_negativo  <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_estado)
        LIBRE: begin
          if (bus.in_valid) begin
            // Subtraction becomes a + ~b + ~ci, so the borrow-in folds into carry0.
            r_a      <= bus.a;
            r_b      <= bus.resta ? ~bus.b : bus.b;
            r_carry  <= bus.ci ^ bus.resta;
            r_cnt    <= {CW{1'b0}};
            r_estado <= CALC;
          end else begin
            r_estado <= LIBRE;
          end
        end
        CALC: begin
          r_s     <= w_s_next;
          r_carry <= w_msb[1];
          if (r_cnt == ULT) begin
            r_coutfin   <= w_msb[1];
            r_desborde  <= w_c_msb ^ w_msb[1];
            r_cero      <= (w_s_next == {ANCHO{1'b0}});
            r_negativo  <= w_s_next[ANCHO-1];
            r_out_valid <= 1'b1;
            r_estado    <= LISTO;
          end else begin
            r_cnt    <= r_cnt + CW'(1);
            r_estado <= CALC;
          end
        end
        LISTO: begin
          if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_estado    <= LIBRE;
          end else begin
            r_estado <= LISTO;
          end
        end
        default: begin
          r_out_valid <= 1'b0;
          r_estado    <= LIBRE;
        end
      endcase
    end
  end

  assign bus.in_ready  = (r_estado == LIBRE);
  assign bus.out_valid = r_out_valid;
  assign bus.s         = r_s;
  assign bus.coutfin   = r_coutfin;
  assign bus.desborde  = r_desborde;
  assign bus.cero      = r_cero;
  assign bus.negativo  = r_negativo;
endmodule

// File: tb/tb_sumac2_segmentado.sv
// Scoreboard bench for sumac2_segmentado: driver pushes model results at
// accept time, a negedge monitor compares whenever out_valid is presented.
module tb_sumac2_segmentado;
  localparam int ANCHO = 64;
  localparam int SEG   = 16;
  localparam int N     = ANCHO / SEG;

  typedef struct packed {
    logic [ANCHO-1:0] s;
    logic             co;
    logic             ov;
    logic             z;
    logic             n;
  } res_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  res_t sb_q[$];
  int   n_emit = 0;
  int   n_done = 0;
  time  t_acc  = 0;
  logic prev_ov = 1'b0;

  sumac2_segmentado_if #(.ANCHO(ANCHO)) bus ();

  sumac2_segmentado #(.ANCHO(ANCHO), .SEG(SEG)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Reference: exact wide arithmetic; overflow = signed result out of ANCHO-bit range.
  function automatic res_t modelo(input logic [ANCHO-1:0] a, input logic [ANCHO-1:0] b,
                                  input logic resta, input logic ci);
    res_t r;
    logic [ANCHO:0] t;
    logic signed [ANCHO+1:0] as_v, bs_v, ex;
    as_v = {{2{a[ANCHO-1]}}, a};
    bs_v = {{2{b[ANCHO-1]}}, b};
    if (!resta) begin
      t  = {1'b0, a} + {1'b0, b} + {{ANCHO{1'b0}}, ci};
      ex = as_v + bs_v + {{(ANCHO+1){1'b0}}, ci};
    end else begin
      t  = {1'b0, a} + {1'b0, ~b} + {{ANCHO{1'b0}}, ~ci};
      ex = as_v - bs_v - {{(ANCHO+1){1'b0}}, ci};
    end
    r.s  = t[ANCHO-1:0];
    r.co = t[ANCHO];
    r.ov = !((ex[ANCHO+1] == ex[ANCHO]) && (ex[ANCHO] == ex[ANCHO-1]));
    r.z  = (r.s == {ANCHO{1'b0}});
    r.n  = r.s[ANCHO-1];
    return r;
  endfunction

  task automatic chk(input string nombre, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nombre, act, exp, $time);
    end
  endtask

  task automatic comparar(input res_t e);
    chk("s",        bus.s,                e.s);
    chk("coutfin",  64'(bus.coutfin),     64'(e.co));
    chk("desborde", 64'(bus.desborde),    64'(e.ov));
    chk("cero",     64'(bus.cero),        64'(e.z));
    chk("negativo", 64'(bus.negativo),    64'(e.n));
  endtask

  // Monitor: compare presented results, check latency and in_ready while busy.
  always @(negedge clk) begin
    if (!rst_n) begin
      sb_q.delete();
      n_done = n_emit;
    end else begin
      if (n_emit != n_done) chk("in_ready_ocupado", 64'(bus.in_ready), 64'd0);
      if (bus.out_valid) begin
        if (!prev_ov) chk("latencia", 64'($time - t_acc), 64'(N * 10 + 5));
        if (sb_q.size() == 0) begin
          chk("out_valid_espurio", 64'(bus.out_valid), 64'd0);
        end else begin
          comparar(sb_q[0]);
          if (bus.out_ready) begin
            void'(sb_q.pop_front());
            n_done++;
          end
        end
      end
    end
    prev_ov = bus.out_valid;
  end

  task automatic emitir(input logic [ANCHO-1:0] a, input logic [ANCHO-1:0] b,
                        input logic resta, input logic ci);
    int k = 0;
    @(posedge clk); #1;
    while (!bus.in_ready && k < 100) begin
      @(posedge clk); #1;
      k++;
    end
    if (!bus.in_ready) begin
      chk("espera_in_ready", 64'(bus.in_ready), 64'd1);
    end else begin
      bus.a = a; bus.b = b; bus.resta = resta; bus.ci = ci;
      bus.in_valid = 1'b1;
      @(posedge clk);
      sb_q.push_back(modelo(a, b, resta, ci));
      t_acc = $time;
      n_emit++;
      #1;
      bus.in_valid = 1'b0;
      bus.a = {$urandom, $urandom};
      bus.b = {$urandom, $urandom};
      bus.resta = 1'($urandom);
      bus.ci = 1'($urandom);
    end
  endtask

  task automatic esperar_fin(input bit aleat);
    int k = 0;
    while (n_done != n_emit && k < 300) begin
      @(posedge clk); #1;
      bus.out_ready = aleat ? ($urandom_range(0, 3) != 0) : 1'b1;
      k++;
    end
    if (n_done != n_emit) chk("timeout_resultado", 64'(n_done), 64'(n_emit));
    bus.out_ready = 1'b1;
  endtask

  logic [ANCHO-1:0] da[10] = '{64'd5, 64'hFFFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF, 64'd3,
                               64'd5, 64'h8000_0000_0000_0000, 64'd5, 64'h0000_0000_FFFF_FFFF,
                               64'h8000_0000_0000_0000, 64'd0};
  logic [ANCHO-1:0] db[10] = '{64'd3, 64'd1, 64'd1, 64'd5, 64'd5, 64'd1, 64'd3, 64'd0,
                               64'h8000_0000_0000_0000, 64'd0};
  logic             dr[10] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
  logic             dc[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

  initial begin
    int k;
    logic [ANCHO-1:0] ra, rb;
    bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.resta = 1'b0; bus.ci = 1'b0;
    bus.out_ready = 1'b1;
    #12;
    chk("rst_in_ready",  64'(bus.in_ready),  64'd1);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    comparar(res_t'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      emitir(da[i], db[i], dr[i], dc[i]);
      esperar_fin(1'b0);
    end

    // Backpressure: result held for 10 cycles while new operands are offered.
    bus.out_ready = 1'b0;
    emitir(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b0, 1'b1);
    k = 0;
    while (!bus.out_valid && k < 20) begin
      @(posedge clk); #1;
      k++;
    end
    chk("bp_out_valid", 64'(bus.out_valid), 64'd1);
    for (int i = 0; i < 10; i++) begin
      bus.in_valid = 1'b1;
      bus.a = {$urandom, $urandom};
      bus.b = {$urandom, $urandom};
      @(posedge clk); #1;
    end
    bus.a = 64'd7; bus.b = 64'd9; bus.resta = 1'b0; bus.ci = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_in_ready_tras_hs", 64'(bus.in_ready),  64'd1);
    chk("bp_out_valid_baja",   64'(bus.out_valid), 64'd0);
    @(posedge clk);
    sb_q.push_back(modelo(64'd7, 64'd9, 1'b0, 1'b0));
    t_acc = $time;
    n_emit++;
    #1;
    bus.in_valid = 1'b0;
    esperar_fin(1'b0);

    // Reset during segment k=2.
    emitir(64'h0123_4567_89AB_CDEF, 64'h1111_2222_3333_4444, 1'b0, 1'b0);
    @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_mid_s",         bus.s,              64'd0);
    chk("rst_mid_in_ready",  64'(bus.in_ready),  64'd1);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    chk("post_rst_in_ready", 64'(bus.in_ready), 64'd1);
    emitir(64'd1, 64'd1, 1'b0, 1'b0);
    esperar_fin(1'b0);

    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 3))
        0: begin ra = {$urandom, $urandom}; rb = {$urandom, $urandom}; end
        1: begin ra = 64'hFFFF_FFFF_FFFF_FFFF; rb = {32'd0, $urandom}; end
        2: begin ra = 64'h7FFF_FFFF_FFFF_0000 | 64'($urandom_range(0, 65535)); rb = 64'($urandom_range(0, 65535)); end
        default: begin ra = 64'h8000_0000_0000_0000; rb = {$urandom, $urandom}; end
      endcase
      emitir(ra, rb, 1'($urandom), 1'($urandom));
      esperar_fin(1'b1);
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end

    repeat (5) @(posedge clk);
    #1;
    chk("scoreboard_vacio", 64'(sb_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
